alu_seq: RTL

Parametrised, registered successor of the 64-bit combinational ALU: a WIDTH-bit execute unit with valid/ready handshakes on input and output, a persistent flag register with per-operation flag-set enable, and an iterative unsigned multiply mode. It sits between the register-read stage and write-back of the pipelined CPU datapath. Each accepted operation produces exactly one output transaction.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit execute unit between register read and write-back.
// Single-cycle ops (pass, add, sub, and, or, xor) complete on the accept edge.
// Multiply iterates one multiplier bit per cycle, LSB first, for WIDTH cycles.
// A persistent flag register is updated only by operations issued with set_flags=1.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid / in_ready     operation handshake (A, B, cntrl, set_flags)
//   out_valid / out_ready   result handshake (result)
//   negative, zero,
//   overflow, carry_out     flag register contents
//
// state | meaning
// IDLE  | output register empty, ready for a new operation
// BUSY  | multiply iterating, input and output both stalled
// HOLD  | result offered on out_valid, waiting for out_ready

module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 accept;
    logic                 is_mul;
    logic                 mul_done;

    logic [WIDTH-1:0]     result_q;
    logic                 neg_q, zero_q, ovf_q, cout_q;

    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;
    logic                 mul_sf_q;
    logic [2*WIDTH-1:0]   acc_next;

    logic                 sub_op;
    logic [WIDTH-1:0]     b_op;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_n, alu_z, alu_v, alu_c;

    // out_ready -> in_ready is the only combinational path through the unit.
    always_comb begin
        in_ready = reset_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        accept   = in_valid && in_ready;
        is_mul   = (cntrl == 3'b111);
        mul_done = (state_q == BUSY) && (cnt_q == CW'(1));
    end

    // Single-cycle ALU. Subtract reuses the adder as A + ~B + 1 so carry_out
    // naturally reads as "no borrow".
    always_comb begin
        sub_op  = (cntrl == 3'b011);
        b_op    = sub_op ? ~B : B;
        sum_ext = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
        alu_res = B;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (cntrl)
            3'b010, 3'b011: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                // Signed overflow: operands agree in sign, sum does not.
                alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b100:  alu_res = A & B;
            3'b101:  alu_res = A | B;
            3'b110:  alu_res = A ^ B;
            default: alu_res = B;   // 000 pass B, 001 reserved behaves as pass B
        endcase
        alu_n = alu_res[WIDTH-1];
        alu_z = (alu_res == '0);
    end

    // Shift-and-add step: multiplicand shifts left, multiplier shifts right.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = is_mul ? BUSY : HOLD;
            end
            BUSY: begin
                if (mul_done) state_d = HOLD;
            end
            HOLD: begin
                if (accept)         state_d = is_mul ? BUSY : HOLD;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mul_sf_q <= 1'b0;
        end else if (accept && !is_mul) begin
            result_q <= alu_res;
            if (set_flags) begin
                neg_q  <= alu_n;
                zero_q <= alu_z;
                ovf_q  <= alu_v;
                cout_q <= alu_c;
            end
        end else if (accept && is_mul) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, A};
            mplier_q <= B;
            cnt_q    <= CW'(WIDTH);
            mul_sf_q <= set_flags;
        end else if (state_q == BUSY) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (mul_done) begin
                result_q <= acc_next[WIDTH-1:0];
                if (mul_sf_q) begin
                    neg_q  <= acc_next[WIDTH-1];
                    zero_q <= (acc_next[WIDTH-1:0] == '0);
                    ovf_q  <= |acc_next[2*WIDTH-1:WIDTH];
                    cout_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        result    = result_q;
        negative  = neg_q;
        zero      = zero_q;
        overflow  = ovf_q;
        carry_out = cout_q;
    end

endmodule
